// File: rtl/msb_req_ctrl.sv
// msb_req_ctrl: per-stream cache-line request arbiter with outstanding
// accounting, response fan-out and per-stream drain/reset sequencing.
// Ports: clk, reset (sync, active-low); i_rd_v/i_rd_r per-stream refill
// requests; o_req_v/o_req_r/o_req_sid registered host request;
// i_rsp_v/i_rsp_r/i_rsp_sid host response; o_rsp_v/o_rsp_r per-stream
// response; i_rst_v/i_rst_r/i_rst_sid stream reset request;
// o_rst_v/o_rst_r per-stream reset completion; o_err sticky underflow.
// Build option: MSB_REQ_RR_ARB_EN selects round-robin arbitration,
// otherwise fixed priority (lowest stream id wins).
module msb_req_ctrl #(
  parameter int nstrms       = 64,
  parameter int nstrms_width = $clog2(nstrms),
  parameter int max_outst    = 4,
  parameter int cnt_width    = $clog2(max_outst + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [nstrms-1:0]       i_rd_v,
  output logic [nstrms-1:0]       i_rd_r,
  output logic                    o_req_v,
  input  logic                    o_req_r,
  output logic [nstrms_width-1:0] o_req_sid,
  input  logic                    i_rsp_v,
  output logic                    i_rsp_r,
  input  logic [nstrms_width-1:0] i_rsp_sid,
  output logic [nstrms-1:0]       o_rsp_v,
  input  logic [nstrms-1:0]       o_rsp_r,
  input  logic                    i_rst_v,
  output logic                    i_rst_r,
  input  logic [nstrms_width-1:0] i_rst_sid,
  output logic [nstrms-1:0]       o_rst_v,
  input  logic [nstrms-1:0]       o_rst_r,
  output logic                    o_err
);

  localparam logic [1:0] ST_ACTIVE = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_RSTOUT = 2'd2;

  localparam logic [cnt_width-1:0] CNT_MAX =
    cnt_width'(max_outst);

  logic [1:0]           st_q  [nstrms];
  logic [1:0]           st_d  [nstrms];
  logic [cnt_width-1:0] cnt_q [nstrms];
  logic [cnt_width-1:0] cnt_d [nstrms];

  logic [nstrms-1:0] act;
  logic [nstrms-1:0] elig;
  logic [nstrms-1:0] gnt;
  logic [nstrms-1:0] inc;
  logic [nstrms-1:0] dec;
  logic [nstrms-1:0] pend;

  logic                    load;
  logic                    any;
  logic [nstrms_width-1:0] gnt_sid;
  logic                    rsp_fire;
  logic                    rst_fire;
  logic                    err_d;

  always_comb begin
    act  = '0;
    elig = '0;
    for (int s = 0; s < nstrms; s++) begin
      act[s]  = (st_q[s] == ST_ACTIVE);
      elig[s] = i_rd_v[s] & act[s]
              & (cnt_q[s] < CNT_MAX);
    end
  end

  // Output register refills when empty or being consumed.
  assign load = ~o_req_v | o_req_r;

`ifdef MSB_REQ_RR_ARB_EN
  logic [nstrms_width-1:0] ptr_q;

  // Rotating search starting at the pointer.
  always_comb begin
    any     = 1'b0;
    gnt_sid = '0;
    for (int i = 0; i < nstrms; i++) begin
      if (!any && elig[(int'(ptr_q) + i) % nstrms]) begin
        any     = 1'b1;
        gnt_sid = nstrms_width'((int'(ptr_q) + i) % nstrms);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= '0;
    end else if (load && any) begin
      if (gnt_sid == nstrms_width'(nstrms - 1))
        ptr_q <= '0;
      else
        ptr_q <= gnt_sid + 1'b1;
    end
  end
`else
  always_comb begin
    any     = 1'b0;
    gnt_sid = '0;
    for (int i = 0; i < nstrms; i++) begin
      if (!any && elig[i]) begin
        any     = 1'b1;
        gnt_sid = nstrms_width'(i);
      end
    end
  end
`endif

  always_comb begin
    gnt = '0;
    if (reset && load && any)
      gnt[gnt_sid] = 1'b1;
  end

  assign i_rd_r = gnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      o_req_v   <= 1'b0;
      o_req_sid <= '0;
    end else if (load) begin
      o_req_v <= any;
      if (any)
        o_req_sid <= gnt_sid;
    end
  end

  // Response fan-out is purely combinational in every stream state.
  always_comb begin
    o_rsp_v = '0;
    for (int s = 0; s < nstrms; s++)
      o_rsp_v[s] = reset & i_rsp_v
                 & (i_rsp_sid == nstrms_width'(s));
  end

  assign i_rsp_r  = reset & o_rsp_r[i_rsp_sid];
  assign rsp_fire = i_rsp_v & i_rsp_r;

  assign i_rst_r  = reset & act[i_rst_sid];
  assign rst_fire = i_rst_v & i_rst_r;

  always_comb begin
    err_d = o_err;
    inc   = '0;
    dec   = '0;
    pend  = '0;
    for (int s = 0; s < nstrms; s++) begin
      inc[s] = gnt[s];
      dec[s] = rsp_fire
             & (i_rsp_sid == nstrms_width'(s))
             & (cnt_q[s] != '0);
      // Response with nothing outstanding: flag, keep counter at 0.
      if (rsp_fire && i_rsp_sid == nstrms_width'(s)
          && cnt_q[s] == '0)
        err_d = 1'b1;
      cnt_d[s] = cnt_q[s];
      if (inc[s] && !dec[s])
        cnt_d[s] = cnt_q[s] + 1'b1;
      else if (!inc[s] && dec[s])
        cnt_d[s] = cnt_q[s] - 1'b1;
      // A request for s still parked in the output register.
      pend[s] = o_req_v & ~o_req_r
              & (o_req_sid == nstrms_width'(s));
      st_d[s] = st_q[s];
      unique case (st_q[s])
        ST_ACTIVE:
          if (rst_fire && i_rst_sid == nstrms_width'(s))
            st_d[s] = ST_DRAIN;
        ST_DRAIN:
          if (cnt_d[s] == '0 && !pend[s])
            st_d[s] = ST_RSTOUT;
        ST_RSTOUT:
          if (o_rst_r[s])
            st_d[s] = ST_ACTIVE;
        default:
          st_d[s] = ST_ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      o_err <= 1'b0;
      for (int s = 0; s < nstrms; s++) begin
        st_q[s]  <= ST_ACTIVE;
        cnt_q[s] <= '0;
      end
    end else begin
      o_err <= err_d;
      for (int s = 0; s < nstrms; s++) begin
        st_q[s]  <= st_d[s];
        cnt_q[s] <= cnt_d[s];
      end
    end
  end

  always_comb begin
    o_rst_v = '0;
    for (int s = 0; s < nstrms; s++)
      o_rst_v[s] = (st_q[s] == ST_RSTOUT);
  end

endmodule

// File: tb/tb_msb_req_ctrl.sv
// tb_msb_req_ctrl: directed self-checking bench for msb_req_ctrl.
// Expectations follow the build option MSB_REQ_RR_ARB_EN.
module tb_msb_req_ctrl;

  localparam int NS = 64;
  localparam int SW = 6;

  localparam logic [NS-1:0] B2 = 64'd1 << 2;
  localparam logic [NS-1:0] B3 = 64'd1 << 3;
  localparam logic [NS-1:0] B4 = 64'd1 << 4;
  localparam logic [NS-1:0] B5 = 64'd1 << 5;
  localparam logic [NS-1:0] B7 = 64'd1 << 7;
  localparam logic [NS-1:0] B9 = 64'd1 << 9;

  logic          clk = 1'b0;
  logic          reset;
  logic [NS-1:0] i_rd_v;
  logic [NS-1:0] i_rd_r;
  logic          o_req_v;
  logic          o_req_r;
  logic [SW-1:0] o_req_sid;
  logic          i_rsp_v;
  logic          i_rsp_r;
  logic [SW-1:0] i_rsp_sid;
  logic [NS-1:0] o_rsp_v;
  logic [NS-1:0] o_rsp_r;
  logic          i_rst_v;
  logic          i_rst_r;
  logic [SW-1:0] i_rst_sid;
  logic [NS-1:0] o_rst_v;
  logic [NS-1:0] o_rst_r;
  logic          o_err;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  msb_req_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .i_rd_v    (i_rd_v),
    .i_rd_r    (i_rd_r),
    .o_req_v   (o_req_v),
    .o_req_r   (o_req_r),
    .o_req_sid (o_req_sid),
    .i_rsp_v   (i_rsp_v),
    .i_rsp_r   (i_rsp_r),
    .i_rsp_sid (i_rsp_sid),
    .o_rsp_v   (o_rsp_v),
    .o_rsp_r   (o_rsp_r),
    .i_rst_v   (i_rst_v),
    .i_rst_r   (i_rst_r),
    .i_rst_sid (i_rst_sid),
    .o_rst_v   (o_rst_v),
    .o_rst_r   (o_rst_r),
    .o_err     (o_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    i_rd_v    = '0;
    o_req_r   = 1'b0;
    i_rsp_v   = 1'b0;
    i_rsp_sid = '0;
    o_rsp_r   = '0;
    i_rst_v   = 1'b0;
    i_rst_sid = '0;
    o_rst_r   = '0;
  endtask

  task automatic do_rst();
    clr();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    i_rd_v    = '1;
    i_rsp_v   = 1'b1;
    i_rsp_sid = 6'd9;
    o_rsp_r   = '1;
    i_rst_v   = 1'b1;
    o_rst_r   = '1;
    o_req_r   = 1'b1;
    #1;
    vecs++;
    if (i_rd_r !== '0) begin
      errs++;
      $display("FAIL rst_rd_r got %h exp 0", i_rd_r);
    end
    vecs++;
    if (i_rsp_r !== 1'b0) begin
      errs++;
      $display("FAIL rst_rsp_r got %b exp 0", i_rsp_r);
    end
    vecs++;
    if (i_rst_r !== 1'b0) begin
      errs++;
      $display("FAIL rst_rst_r got %b exp 0", i_rst_r);
    end
    vecs++;
    if (o_rsp_v !== '0) begin
      errs++;
      $display("FAIL rst_rsp_v got %h exp 0", o_rsp_v);
    end
    step();
    vecs++;
    if ({o_req_v, o_req_sid} !== 7'd0) begin
      errs++;
      $display("FAIL rst_req got %b/%0d exp 0/0",
               o_req_v, o_req_sid);
    end
    vecs++;
    if (o_err !== 1'b0 || o_rst_v !== '0) begin
      errs++;
      $display("FAIL rst_err_rstv got %b/%h exp 0/0",
               o_err, o_rst_v);
    end
    clr();
    reset = 1'b1;
  endtask

  task automatic test_max_outst();
    logic [NS-1:0] e;
    do_rst();
    i_rd_v  = B3;
    o_req_r = 1'b1;
    for (int k = 0; k < 7; k++) begin
      #1;
      e = (k < 4) ? B3 : '0;
      vecs++;
      if (i_rd_r !== e) begin
        errs++;
        $display("FAIL max_rd_r[%0d] got %h exp %h",
                 k, i_rd_r, e);
      end
      step();
      vecs++;
      if (o_req_v !== (k < 4)) begin
        errs++;
        $display("FAIL max_req_v[%0d] got %b exp %b",
                 k, o_req_v, (k < 4));
      end
      if (k < 4) begin
        vecs++;
        if (o_req_sid !== 6'd3) begin
          errs++;
          $display("FAIL max_sid[%0d] got %0d exp 3",
                   k, o_req_sid);
        end
      end
    end
  endtask

  task automatic test_arb();
    int exp_sid [6];
`ifdef MSB_REQ_RR_ARB_EN
    exp_sid = '{0, 1, 2, 0, 1, 2};
`else
    exp_sid = '{0, 0, 0, 0, 1, 1};
`endif
    do_rst();
    i_rd_v  = 64'h7;
    o_req_r = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      vecs++;
      if (o_req_v !== 1'b1 ||
          o_req_sid !== SW'(exp_sid[k])) begin
        errs++;
        $display("FAIL arb[%0d] got %b/%0d exp 1/%0d",
                 k, o_req_v, o_req_sid, exp_sid[k]);
      end
    end
  endtask

  task automatic test_drain();
    do_rst();
    i_rd_v  = B5;
    o_req_r = 1'b1;
    step();
    step();
    i_rd_v    = '0;
    i_rst_v   = 1'b1;
    i_rst_sid = 6'd5;
    #1;
    vecs++;
    if (i_rst_r !== 1'b1) begin
      errs++;
      $display("FAIL drn_rst_r got %b exp 1", i_rst_r);
    end
    step();
    i_rst_v = 1'b0;
    i_rd_v  = B5;
    i_rsp_v   = 1'b1;
    i_rsp_sid = 6'd5;
    o_rsp_r   = B5;
    #1;
    vecs++;
    if (i_rd_r !== '0 || i_rst_r !== 1'b0) begin
      errs++;
      $display("FAIL drn_block got %h/%b exp 0/0",
               i_rd_r, i_rst_r);
    end
    vecs++;
    if (o_rsp_v !== B5 || i_rsp_r !== 1'b1) begin
      errs++;
      $display("FAIL drn_rsp got %h/%b exp %h/1",
               o_rsp_v, i_rsp_r, B5);
    end
    step();
    vecs++;
    if (o_rst_v !== '0) begin
      errs++;
      $display("FAIL drn_early got %h exp 0", o_rst_v);
    end
    step();
    i_rsp_v = 1'b0;
    #1;
    vecs++;
    if (o_rst_v !== B5 || i_rd_r !== '0) begin
      errs++;
      $display("FAIL drn_rstout got %h/%h exp %h/0",
               o_rst_v, i_rd_r, B5);
    end
    step();
    vecs++;
    if (o_rst_v !== B5) begin
      errs++;
      $display("FAIL drn_hold got %h exp %h",
               o_rst_v, B5);
    end
    o_rst_r = B5;
    step();
    o_rst_r = '0;
    #1;
    vecs++;
    if (o_rst_v !== '0 || i_rd_r !== B5) begin
      errs++;
      $display("FAIL drn_resume got %h/%h exp 0/%h",
               o_rst_v, i_rd_r, B5);
    end
    step();
    vecs++;
    if (o_req_v !== 1'b1 || o_req_sid !== 6'd5) begin
      errs++;
      $display("FAIL drn_req got %b/%0d exp 1/5",
               o_req_v, o_req_sid);
    end
  endtask

  task automatic test_same_cycle();
    int cnt;
    do_rst();
    i_rd_v  = B7;
    o_req_r = 1'b1;
    step();
    i_rsp_v   = 1'b1;
    i_rsp_sid = 6'd7;
    o_rsp_r   = B7;
    #1;
    vecs++;
    if (i_rd_r !== B7 || i_rsp_r !== 1'b1) begin
      errs++;
      $display("FAIL same_fire got %h/%b exp %h/1",
               i_rd_r, i_rsp_r, B7);
    end
    step();
    i_rsp_v = 1'b0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (i_rd_r[7]) cnt++;
      step();
    end
    vecs++;
    if (cnt !== 3) begin
      errs++;
      $display("FAIL same_grants got %0d exp 3", cnt);
    end
  endtask

  task automatic test_err();
    do_rst();
    i_rsp_v   = 1'b1;
    i_rsp_sid = 6'd9;
    o_rsp_r   = B9;
    #1;
    vecs++;
    if (o_rsp_v !== B9 || o_err !== 1'b0) begin
      errs++;
      $display("FAIL err_fwd got %h/%b exp %h/0",
               o_rsp_v, o_err, B9);
    end
    step();
    clr();
    vecs++;
    if (o_err !== 1'b1) begin
      errs++;
      $display("FAIL err_set got %b exp 1", o_err);
    end
    step();
    step();
    step();
    vecs++;
    if (o_err !== 1'b1) begin
      errs++;
      $display("FAIL err_sticky got %b exp 1", o_err);
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    vecs++;
    if (o_err !== 1'b0) begin
      errs++;
      $display("FAIL err_clear got %b exp 0", o_err);
    end
  endtask

  task automatic test_stall();
    logic [NS-1:0] e;
`ifdef MSB_REQ_RR_ARB_EN
    e = B4;
`else
    e = B2;
`endif
    do_rst();
    i_rd_v  = B2 | B4;
    o_req_r = 1'b0;
    step();
    for (int k = 0; k < 10; k++) begin
      #1;
      vecs++;
      if (i_rd_r !== '0 || o_req_v !== 1'b1 ||
          o_req_sid !== 6'd2) begin
        errs++;
        $display("FAIL stall[%0d] got %h/%b/%0d exp 0/1/2",
                 k, i_rd_r, o_req_v, o_req_sid);
      end
      step();
    end
    o_req_r = 1'b1;
    #1;
    vecs++;
    if (i_rd_r !== e) begin
      errs++;
      $display("FAIL stall_release got %h exp %h",
               i_rd_r, e);
    end
    o_req_r = 1'b0;
    step();
    reset = 1'b0;
    step();
    vecs++;
    if (o_req_v !== 1'b0 || o_rst_v !== '0) begin
      errs++;
      $display("FAIL mid_reset got %b/%h exp 0/0",
               o_req_v, o_rst_v);
    end
    reset = 1'b1;
    clr();
  endtask

  initial begin
    reset = 1'b0;
    clr();
    test_reset();
    test_max_outst();
    test_arb();
    test_drain();
    test_same_cycle();
    test_err();
    test_stall();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule

// File: doc/msb_req_ctrl.md
MSB_REQ_CTRL -- requirements
Module: msb_req_ctrl

Interface
REQ-001 Parameter: nstrms, 64, number of streams.
REQ-002 Parameter: nstrms_width, $clog2(nstrms), stream id width.
REQ-003 Parameter: max_outst, 4, outstanding cache-line requests allowed per stream (1..15).
REQ-004 Parameter: cnt_width, $clog2(max_outst+1), per-stream outstanding counter width.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 i_rd_v / i_rd_r  in / out  nstrms / nstrms  per-stream cache-line refill request handshake.
REQ-008 o_req_v / o_req_r / o_req_sid  out / in / out  1 / 1 / nstrms_width  request to host interface.
REQ-009 i_rsp_v / i_rsp_r / i_rsp_sid  in / out / in  1 / 1 / nstrms_width  response from host interface.
REQ-010 o_rsp_v / o_rsp_r  out / in  nstrms / nstrms  per-stream decoded response handshake.
REQ-011 i_rst_v / i_rst_r / i_rst_sid  in / out / in  1 / 1 / nstrms_width  functional stream reset request.
REQ-012 o_rst_v / o_rst_r  out / in  nstrms / nstrms  per-stream reset completion handshake.
REQ-013 o_err  out  1  sticky: response received for stream with zero outstanding.

Function
REQ-014 Per-stream state SHALL be one of ACTIVE, DRAIN, RSTOUT, plus counter outst[s].
REQ-015 Stream s is eligible when i_rd_v[s]=1, state ACTIVE, outst[s]<max_outst.
REQ-016 Output stage SHALL be one register (o_req_v, o_req_sid); loads when o_req_v=0 or o_req_r=1; 1-cycle latency i_rd_v to o_req_v.
REQ-017 On load with >=1 eligible stream, arbiter grants exactly one s: i_rd_r[s]=1 same cycle, all other i_rd_r=0; no eligible stream -> o_req_v cleared.
REQ-018 outst[s] SHALL increment on grant to s, decrement on i_rsp_v&i_rsp_r with i_rsp_sid=s; both same cycle -> unchanged.
REQ-019 Response path combinational: o_rsp_v[s]=i_rsp_v&(i_rsp_sid==s); i_rsp_r=o_rsp_r[i_rsp_sid]; forwarded in all states.
REQ-020 Response with outst[s]=0: forwarded, counter held at 0, o_err set until reset.
REQ-021 i_rst_r=1 iff state[i_rst_sid]=ACTIVE; on i_rst_v&i_rst_r stream enters DRAIN next cycle; same-cycle grant to that stream still completes and counts.
REQ-022 DRAIN -> RSTOUT when outst[s]=0 and output register holds no valid request for s.
REQ-023 RSTOUT: o_rst_v[s]=1 held; on o_rst_r[s]=1 -> ACTIVE next cycle.
REQ-024 DRAIN/RSTOUT streams never granted; i_rd_r[s]=0.
REQ-025 outst never exceeds max_outst; counters never wrap.

Reset
REQ-026 reset=0 at clk edge: all streams ACTIVE, outst=0, o_req_v=0, o_req_sid=0, o_err=0, arbiter pointer=0, o_rst_v=0.
REQ-027 Reset mid-operation discards outstanding accounting and in-flight o_req without issuing o_rst_v.
REQ-028 Combinational outputs (i_rd_r, i_rsp_r, i_rst_r, o_rsp_v) SHALL be 0 while reset=0.

Configuration
REQ-029 MSB_REQ_RR_ARB_EN defined: round-robin; search starts at pointer, pointer=granted sid+1 mod nstrms after each grant.
REQ-030 MSB_REQ_RR_ARB_EN undefined: fixed priority, lowest eligible sid wins; no pointer state.

Verification
REQ-031 Stream 3 i_rd_v held, o_req_r=1, no responses -> exactly 4 requests sid=3 on consecutive cycles, then i_rd_r[3]=0.
REQ-032 RR build, streams 0,1,2 requesting, o_req_r=1 -> o_req_sid 0,1,2,0,1,2; fixed build -> 0,0,0,0 then 1 (after stream 0 reaches max_outst).
REQ-033 Stream 5 outst=2, i_rst sid=5 -> i_rd_r[5]=0; two responses sid=5 -> o_rst_v[5]=1 cycle after second; o_rst_r[5]=1 -> ACTIVE, requests resume.
REQ-034 Grant and response to stream 7 in same cycle at outst=1 -> outst stays 1.
REQ-035 Response sid=9 with outst[9]=0 -> o_rsp_v[9]=1, o_err=1 persists until reset=0.
REQ-036 o_req_r=0 for 10 cycles with o_req_v=1 -> o_req_sid stable, no i_rd_r asserted.
